// File: rtl/serv_ibus_responder.sv
// Instruction-bus responder: answers ibus fetches from a DEPTH x 32 array after WAIT_STATES cycles.
// Define SERV_IBUS_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module serv_ibus_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter     MEMFILE     = ""
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic [31:0]              i_ibus_adr,
    input  logic                     i_ibus_cyc,
    output logic [31:0]              o_ibus_rdt,
    output logic                     o_ibus_ack,
    output logic                     o_ibus_err,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_adr,
    input  logic [31:0]              i_ld_dat,
    output logic                     o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_RESP, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   rdt_q;
    logic [31:0]   mem [DEPTH];

    logic req_bad;
    logic pf_hit;

    // Out-of-range uses the full word address so high address bits never alias.
    assign req_bad = (|i_ibus_adr[1:0]) || (i_ibus_adr[31:2] >= 30'(DEPTH));

`ifdef SERV_IBUS_PREFETCH_EN
    logic          pf_vld_q, pf_vld_d;
    logic [AW-1:0] pf_idx_q;
    logic [31:0]   pf_dat_q;
    logic          pf_fill;
    logic [AW-1:0] nxt_idx;

    assign nxt_idx = idx_q + AW'(1);
    assign pf_fill = (state_q == S_GAP) && !err_q && (idx_q != AW'(DEPTH - 1));
    assign pf_hit  = pf_vld_q && !req_bad && (i_ibus_adr[2+:AW] == pf_idx_q);

    // A load to the entry being filled or held must never leave stale data marked valid.
    always_comb begin
        pf_vld_d = pf_vld_q;
        if (state_q == S_IDLE && i_ibus_cyc && !pf_hit)
            pf_vld_d = 1'b0;
        if (pf_fill)
            pf_vld_d = 1'b1;
        if (i_ld_en && (i_ld_adr == (pf_fill ? nxt_idx : pf_idx_q)))
            pf_vld_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n)
            pf_vld_q <= 1'b0;
        else
            pf_vld_q <= pf_vld_d;
    end

    always_ff @(posedge clk) begin
        if (pf_fill) begin
            pf_idx_q <= nxt_idx;
            pf_dat_q <= mem[nxt_idx];
        end
    end
`else
    assign pf_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_ibus_cyc) begin
                    err_d = req_bad;
                    if (req_bad || pf_hit) begin
                        state_d = S_RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WAIT: begin
                if (!i_ibus_cyc)
                    state_d = S_IDLE;
                else if (cnt_q == 4'd0)
                    state_d = S_READ;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            S_READ:  state_d = i_ibus_cyc ? S_RESP : S_IDLE;
            S_RESP:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Nonblocking read/write on the same edge gives old data on a READ/load collision.
    always_ff @(posedge clk) begin
        if (i_ld_en)
            mem[i_ld_adr] <= i_ld_dat;
        if (state_q == S_IDLE && i_ibus_cyc)
            idx_q <= i_ibus_adr[2+:AW];
        if (state_q == S_READ)
            rdt_q <= mem[idx_q];
`ifdef SERV_IBUS_PREFETCH_EN
        else if (state_q == S_IDLE && i_ibus_cyc && pf_hit)
            rdt_q <= pf_dat_q;
`endif
    end

    always_comb begin
        o_busy     = (state_q != S_IDLE);
        o_ibus_ack = (state_q == S_RESP) && !err_q;
        o_ibus_err = (state_q == S_RESP) && err_q;
        o_ibus_rdt = o_ibus_ack ? rdt_q : 32'h0;
    end

endmodule

// File: tb/tb_serv_ibus_responder.sv
// Bench for serv_ibus_responder: cycle-level behavioural model plus directed literal checks.
module tb_serv_ibus_responder;
    localparam int DEPTH = 16;
    localparam int WS    = 1;
    localparam int AW    = 4;
`ifdef SERV_IBUS_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic [31:0]   i_ibus_adr;
    logic          i_ibus_cyc;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;
    logic          o_ibus_err;
    logic          i_ld_en;
    logic [AW-1:0] i_ld_adr;
    logic [31:0]   i_ld_dat;
    logic          o_busy;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    serv_ibus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .MEMFILE("")) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack), .o_ibus_err(o_ibus_err),
        .i_ld_en(i_ld_en), .i_ld_adr(i_ld_adr), .i_ld_dat(i_ld_dat), .o_busy(o_busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc_n, act, exp);
        end
    endtask

    // Behavioural model: tracks one request by the cycle numbers its response must land on.
    logic [31:0] mm [DEPTH];
    bit          known = 0, req_act = 0, req_err = 0, req_hit = 0;
    int          req_T = 0, req_R = 0, req_idx = 0, idle_from = 0;
    logic [31:0] req_dat = 32'h0;
    bit          pf_vld = 0;
    int          pf_idx = 0;
    logic [31:0] pf_dat = 32'h0;

    task automatic model_step();
        int k;
        logic ea, ee, eb;
        logic [31:0] er;
        k  = cyc_n;
        eb = (k < idle_from);
        ea = req_act && (k == req_R) && !req_err;
        ee = req_act && (k == req_R) && req_err;
        er = ea ? req_dat : 32'h0;
        if (known) begin
            chk("m_ack", {31'h0, o_ibus_ack}, {31'h0, ea});
            chk("m_err", {31'h0, o_ibus_err}, {31'h0, ee});
            chk("m_rdt", o_ibus_rdt, er);
            chk("m_busy", {31'h0, o_busy}, {31'h0, eb});
        end
        if (!i_rst_n) begin
            req_act   = 0;
            idle_from = k + 1;
            pf_vld    = 0;
            known     = 1;
        end else begin
            if (req_act && !req_err && !req_hit && k == req_R - 1)
                req_dat = mm[req_idx];
            if (PF && req_act && !req_err && k == req_R + 1) begin
                pf_vld = (req_idx + 1 < DEPTH);
                pf_idx = req_idx + 1;
                if (pf_vld) pf_dat = mm[pf_idx];
            end
            if (req_act && !req_err && !req_hit && k > req_T && k < req_R && !i_ibus_cyc) begin
                req_act   = 0;
                idle_from = k + 1;
            end
            if (k >= idle_from && i_ibus_cyc) begin
                req_err = (i_ibus_adr[1:0] != 2'b00) || (i_ibus_adr[31:2] >= DEPTH);
                req_idx = int'(i_ibus_adr[5:2]);
                req_hit = PF && pf_vld && !req_err && (req_idx == pf_idx);
                req_dat = req_hit ? pf_dat : 32'h0;
                if (!req_hit) pf_vld = 0;
                req_T     = k;
                req_R     = (req_err || req_hit) ? k + 1 : k + 2 + WS;
                idle_from = req_R + 2;
                req_act   = 1;
            end
        end
        if (i_ld_en) begin
            mm[i_ld_adr] = i_ld_dat;
            if (pf_vld && int'(i_ld_adr) == pf_idx) pf_vld = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        i_ld_en  = 1'b1;
        i_ld_adr = AW'(idx);
        i_ld_dat = d;
        tick();
        i_ld_en  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] adr, output int lat, output logic [31:0] d,
                         output logic e);
        int t0, n;
        i_ibus_cyc = 1'b1;
        i_ibus_adr = adr;
        t0 = cyc_n;
        n  = 0;
        do begin
            tick();
            n++;
        end while (!(o_ibus_ack || o_ibus_err) && n < 40);
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout adr=%h: no ack/err within 40 cycles", adr);
        end
        lat = cyc_n - t0;
        d   = o_ibus_rdt;
        e   = o_ibus_err;
        i_ibus_cyc = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] d;
        logic e;
        i_rst_n = 1'b0; i_ibus_cyc = 1'b1; i_ibus_adr = 32'hC;
        i_ld_en = 1'b0; i_ld_adr = '0; i_ld_dat = 32'h0;

        // Reset held with a pending request: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_ack", {31'h0, o_ibus_ack}, 32'h0);
            chk("rst_err", {31'h0, o_ibus_err}, 32'h0);
            chk("rst_rdt", o_ibus_rdt, 32'h0);
            chk("rst_busy", {31'h0, o_busy}, 32'h0);
        end
        i_ibus_cyc = 1'b0;
        i_rst_n    = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            if (i == 2)      load(i, 32'h1111_1111);
            else if (i == 3) load(i, 32'h0050_0093);
            else             load(i, 32'hC0DE_0000 + 32'(i));
        end
        tick();

        fetch(32'hC, lat, d, e);
        chk("t2_lat", lat, 3);
        chk("t2_rdt", d, 32'h0050_0093);
        chk("t2_err", {31'h0, e}, 32'h0);

        fetch(32'h6, lat, d, e);
        chk("t3_mis_lat", lat, 1);
        chk("t3_mis_err", {31'h0, e}, 32'h1);
        chk("t3_mis_rdt", d, 32'h0);
        fetch(32'(DEPTH * 4), lat, d, e);
        chk("t3_oor_lat", lat, 1);
        chk("t3_oor_err", {31'h0, e}, 32'h1);
        chk("t3_oor_rdt", d, 32'h0);
        fetch(32'h8000_0008, lat, d, e);
        chk("t3_alias_err", {31'h0, e}, 32'h1);

        // Abort in WAIT.
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h0;
        tick();
        chk("t4_busy_wait", {31'h0, o_busy}, 32'h1);
        i_ibus_cyc = 1'b0;
        tick();
        chk("t4_busy_idle", {31'h0, o_busy}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_ack", {31'h0, o_ibus_ack}, 32'h0);
            chk("t4_no_err", {31'h0, o_ibus_err}, 32'h0);
            tick();
        end

        // Load collides with the READ cycle of a fetch of the same word.
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h8;
        tick();
        tick();
        i_ld_en = 1'b1; i_ld_adr = 4'd2; i_ld_dat = 32'hAAAA_AAAA;
        tick();
        i_ld_en = 1'b0;
        chk("t5_ack", {31'h0, o_ibus_ack}, 32'h1);
        chk("t5_old", o_ibus_rdt, 32'h1111_1111);
        i_ibus_cyc = 1'b0;
        tick();
        tick();
        fetch(32'h8, lat, d, e);
        chk("t5_new", d, 32'hAAAA_AAAA);
        chk("t5_lat", lat, 3);

        // Sequential fetches: buffered next word when prefetch is built in.
        fetch(32'h0, lat, d, e);
        chk("t6_w0_lat", lat, 3);
        chk("t6_w0_rdt", d, 32'hC0DE_0000);
        fetch(32'h4, lat, d, e);
        chk("t6_w1_lat", lat, PF ? 1 : 3);
        chk("t6_w1_rdt", d, 32'hC0DE_0001);
        fetch(32'h8, lat, d, e);
        chk("t6_w2_lat", lat, PF ? 1 : 3);
        chk("t6_w2_rdt", d, 32'hAAAA_AAAA);
        fetch(32'h0, lat, d, e);
        load(1, 32'h1234_5678);
        fetch(32'h4, lat, d, e);
        chk("t6_ld_lat", lat, 3);
        chk("t6_ld_rdt", d, 32'h1234_5678);

        // Last word must not prefetch a wrapped index.
        fetch(32'(DEPTH * 4 - 4), lat, d, e);
        chk("t6_last_rdt", d, 32'hC0DE_000F);
        fetch(32'h0, lat, d, e);
        chk("t6_wrap_lat", lat, 3);
        chk("t6_wrap_rdt", d, 32'hC0DE_0000);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
